// File: rtl/hazard_track_unit.sv
// Hazard and forwarding-producer unit: tracks MEM/WB destinations and drives
// pipeline enables for load-use stall, taken-branch flush and multi-cycle load freeze.
module hazard_track_unit #(
  parameter int unsigned LOAD_EXTRA = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_tk,
  output logic             mem_wb,
  output logic [4:0]       mem_rd,
  output logic             wb_wb,
  output logic [4:0]       wb_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  localparam logic [3:0]       LOAD_CNT = (LOAD_EXTRA > 0) ? 4'(LOAD_EXTRA - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic [3:0] cnt;
  logic       mem_load;
  logic       load_use;

  // LOAD_WAIT is only ever entered with a load latched in MEM, so qualifying
  // with mem_load does not change behaviour.
  assign freeze = (state == LOAD_WAIT) && mem_load;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_branch_tk) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      mem_wb       <= 1'b0;
      mem_rd       <= '0;
      mem_load     <= 1'b0;
      wb_wb        <= 1'b0;
      wb_rd        <= '0;
      stall_cycles <= '0;
    end else begin
      if (!freeze) begin
        mem_wb   <= ex_reg_write;
        mem_rd   <= ex_rd;
        mem_load <= ex_mem_read;
        wb_wb    <= mem_wb;
        wb_rd    <= mem_rd;
      end

      case (state)
        RUN: begin
          if (ex_mem_read && (LOAD_EXTRA > 0)) begin
            state <= LOAD_WAIT;
            cnt   <= LOAD_CNT;
          end
        end
        LOAD_WAIT: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= RUN;
      endcase

      if (!pc_write && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit: one instance with single-cycle memory
// and a narrow stall counter, one with a two-cycle load freeze.
module tb_hazard_track_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_reg_write, ex_mem_read, ex_branch_tk;

  logic       mem_wb0, wb_wb0, pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0;
  logic [4:0] mem_rd0, wb_rd0;
  logic [1:0] stall0;
  logic       mem_wb2, wb_wb2, pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2;
  logic [4:0] mem_rd2, wb_rd2;
  logic [15:0] stall2;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  hazard_track_unit #(.LOAD_EXTRA(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_tk(ex_branch_tk), .mem_wb(mem_wb0), .mem_rd(mem_rd0),
    .wb_wb(wb_wb0), .wb_rd(wb_rd0), .pc_write(pc_write0), .ifid_write(ifid_write0),
    .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0), .freeze(freeze0),
    .stall_cycles(stall0)
  );

  hazard_track_unit #(.LOAD_EXTRA(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_tk(ex_branch_tk), .mem_wb(mem_wb2), .mem_rd(mem_rd2),
    .wb_wb(wb_wb2), .wb_rd(wb_rd2), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .freeze(freeze2),
    .stall_cycles(stall2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; ex_branch_tk = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
  task automatic test_reset();
    do_reset();
    total++;
    if ({pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0} !== 5'b11000)
      $display("FAIL reset_ctrl0 got=%b exp=%b",
               {pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0}, 5'b11000);
    else passed++;
    total++;
    if ({mem_wb2, mem_rd2, wb_wb2, wb_rd2, stall2} !== 28'd0)
      $display("FAIL reset_track2 got=%h exp=0", {mem_wb2, mem_rd2, wb_wb2, wb_rd2, stall2});
    else passed++;
    total++;
    if ({pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2} !== 5'b11000)
      $display("FAIL reset_ctrl2 got=%b exp=%b",
               {pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2}, 5'b11000);
    else passed++;
  endtask

  task automatic test_tracking();
    do_reset();
    ex_reg_write = 1'b1; ex_rd = 5'd7;
    tick();
    idle();
    total++;
    if ({mem_wb0, mem_rd0, wb_wb0, wb_rd0} !== {1'b1, 5'd7, 1'b0, 5'd0})
      $display("FAIL track_mem got=%h exp=%h", {mem_wb0, mem_rd0, wb_wb0, wb_rd0},
               {1'b1, 5'd7, 1'b0, 5'd0});
    else passed++;
    tick();
    total++;
    if ({mem_wb0, mem_rd0, wb_wb0, wb_rd0} !== {1'b0, 5'd0, 1'b1, 5'd7})
      $display("FAIL track_wb got=%h exp=%h", {mem_wb0, mem_rd0, wb_wb0, wb_rd0},
               {1'b0, 5'd0, 1'b1, 5'd7});
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    total++;
    if ({pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0} !== 5'b00010)
      $display("FAIL load_use_ctrl got=%b exp=%b",
               {pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0}, 5'b00010);
    else passed++;
    tick();
    idle();
    #1;
    total++;
    if ({pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0} !== 5'b11000)
      $display("FAIL load_use_release got=%b exp=%b",
               {pc_write0, ifid_write0, ifid_flush0, idex_bubble0, freeze0}, 5'b11000);
    else passed++;
    total++;
    if (stall0 !== 2'd1) $display("FAIL load_use_stall_cnt got=%0d exp=1", stall0);
    else passed++;
  endtask

  task automatic test_no_stall();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    total++;
    if ({pc_write0, ifid_write0, idex_bubble0} !== 3'b110)
      $display("FAIL r0_no_stall got=%b exp=110", {pc_write0, ifid_write0, idex_bubble0});
    else passed++;
    tick();
    idle();
    #1;
    total++;
    if (stall0 !== 2'd0) $display("FAIL r0_stall_cnt got=%0d exp=0", stall0);
    else passed++;
    total++;
    if (freeze2 !== 1'b1) $display("FAIL r0_load_freezes got=%b exp=1", freeze2);
    else passed++;

    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    total++;
    if ({pc_write0, ifid_write0, idex_bubble0} !== 3'b110)
      $display("FAIL rt_unused_no_stall got=%b exp=110", {pc_write0, ifid_write0, idex_bubble0});
    else passed++;
    id_uses_rt = 1'b1;
    #1;
    total++;
    if ({pc_write0, ifid_write0, idex_bubble0} !== 3'b001)
      $display("FAIL rt_used_stall got=%b exp=001", {pc_write0, ifid_write0, idex_bubble0});
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_load_freeze();
    do_reset();
    ex_reg_write = 1'b1; ex_rd = 5'd9;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd4;
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd12;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2} !== 5'b00001)
        $display("FAIL freeze_ctrl cyc=%0d got=%b exp=00001", i,
                 {pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2});
      else passed++;
      total++;
      if ({mem_rd2, wb_rd2} !== {5'd4, 5'd9})
        $display("FAIL freeze_hold cyc=%0d got=%0d/%0d exp=4/9", i, mem_rd2, wb_rd2);
      else passed++;
      tick();
    end
    total++;
    if ({pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2} !== 5'b11000)
      $display("FAIL freeze_end got=%b exp=11000",
               {pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2});
    else passed++;
    total++;
    if (stall2 !== 16'd2) $display("FAIL freeze_stall_cnt got=%0d exp=2", stall2);
    else passed++;
    tick();
    idle();
    total++;
    if ({mem_rd2, wb_rd2} !== {5'd12, 5'd4})
      $display("FAIL freeze_advance got=%0d/%0d exp=12/4", mem_rd2, wb_rd2);
    else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_tk = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    total++;
    if ({pc_write0, ifid_flush0, idex_bubble0, freeze0} !== 4'b1110)
      $display("FAIL branch_ctrl got=%b exp=1110",
               {pc_write0, ifid_flush0, idex_bubble0, freeze0});
    else passed++;
    tick();
    idle();
    total++;
    if (stall0 !== 2'd0) $display("FAIL branch_stall_cnt got=%0d exp=0", stall0);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (stall0 !== ((i > 3) ? 2'd3 : 2'(i)))
        $display("FAIL stall_saturate cyc=%0d got=%0d exp=%0d", i, stall0, (i > 3) ? 3 : i);
      else passed++;
    end
    idle();
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6;
    tick();
    idle();
    total++;
    if ({freeze2, mem_rd2} !== {1'b1, 5'd6})
      $display("FAIL mid_freeze_entry got=%b/%0d exp=1/6", freeze2, mem_rd2);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2} !== 5'b11000)
      $display("FAIL mid_freeze_abort got=%b exp=11000",
               {pc_write2, ifid_write2, ifid_flush2, idex_bubble2, freeze2});
    else passed++;
    total++;
    if ({mem_wb2, mem_rd2, wb_wb2, wb_rd2, stall2} !== 28'd0)
      $display("FAIL mid_freeze_clear got=%h exp=0", {mem_wb2, mem_rd2, wb_wb2, wb_rd2, stall2});
    else passed++;
    tick();
    total++;
    if ({freeze2, stall2} !== 17'd0)
      $display("FAIL mid_freeze_stays_run got=%b/%0d exp=0/0", freeze2, stall2);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_tracking();
    test_load_use();
    test_no_stall();
    test_load_freeze();
    test_branch();
    test_saturation();
    test_reset_mid_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
